l2_shared_arbiter: RTL and testbench
====================================

# l2_shared_arbiter

Sequencer and two-way arbiter for the shared L2 cache subsystem in the dual-core build. It accepts load-miss and flush (write-back) requests from the two per-core L1 controllers and grants one requester at a time. It drives the L2 command/bus ports for the granted requester and steps the L2 through hit, miss-fill and flush sequences. It returns completion and load data to the granted core.

## Interface
Parameters:
- MISS_LAT, 4: cycles spent waiting on data memory after an L2 load miss, before the fill cycle; legal range 1–15.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  2  per-core request, bit N = core N; held high until done[N]
- req_flush  in  2  per-core op: 1 = flush/write-back, 0 = load; stable while req[N]
- req_addr  in  64  core N address in [32N+31:32N]
- req_wdata  in  64  core N write-back data in [32N+31:32N]
- gnt  out  2  one-hot, one-cycle pulse when a request is accepted
- done  out  2  one-hot, one-cycle pulse at completion
- rdata  out  32  load data, valid only while done is asserted for a load
- l2_rd_en  out  1  high during load phases
- l2_flush  out  1  high for exactly the flush issue cycle
- l2_opcode  out  7  7'b0000011 during load phases, else 0
- l2_bus_address  out  32  granted address
- l2_bus_data  out  32  granted write-back data, flush only
- l2_bus_tag  out  24  granted address [31:8]
- l2_cache_hit  in  2  L2 hit status: 2'b10 hit, 2'b01 miss
- l2_data  in  32  L2 load-hit data
- dmem_data  in  32  data-memory read data; valid in FILL

## Operation
- FSM states: IDLE, ISSUE, MISS, FILL, RESP. Reset enters IDLE with:
  - gnt, done, rdata, all l2_* outputs = 0
  - miss counter = 0
  - priority pointer = core 0
- IDLE:
  - If req is nonzero, choose the winner: the sole requester, or the pointer core if both request.
  - Latch winner index, address, data and op; go to ISSUE.
- ISSUE:
  - gnt[winner] = 1. L2 ports are driven from the latched values.
  - Flush: l2_flush = 1, then go to RESP.
  - Load: l2_rd_en = 1 and l2_opcode = load.
    - l2_cache_hit == 2'b10: capture l2_data into rdata, go to RESP.
    - Any other value (01, 00, 11): load counter with MISS_LAT-1, go to MISS.
- MISS:
  - Load opcode and address stay driven.
  - Counter decrements each cycle; at 0, go to FILL.
- FILL:
  - Load opcode held; L2 refills from dmem_data.
  - Capture dmem_data into rdata, go to RESP.
- RESP:
  - done[winner] = 1; l2_rd_en, l2_flush and l2_opcode = 0.
  - Pointer set to the non-winner core; go to IDLE.
- Between IDLE and RESP, req changes are ignored; the latched transaction always completes.
- Simultaneous req = 2'b11: the pointer core wins. The loser is granted on the next IDLE visit if it still requests.
- A single requester wins regardless of pointer. Pointer updates only in RESP.
- Reset mid-transaction aborts immediately to the reset state; no done is issued.

## Timing
- Grant cycle G is the cycle after req is sampled in IDLE.
- Done timing:
  - Load hit: done at G+1.
  - Flush: done at G+1.
  - Load miss: done at G+MISS_LAT+2.
- Minimum spacing between consecutive grants is 3 cycles (ISSUE, RESP, IDLE).
- All outputs are registered-state decodes; no combinational path from req to gnt.
- rdata holds its value after done until the next capture.

## Configuration
- L2_ARB_FIXED_PRIO_EN defined:
  - Core 0 always wins simultaneous requests; the pointer is unused.
  - Core 1 may starve.
- Undefined (default): round-robin pointer as described above.

## Test plan
- Reset, then req=2'b01 load with addr 0x0000_1004 and l2_cache_hit=10, l2_data=0xDEAD_BEEF -> gnt=01 at G, done=01 at G+1, rdata=0xDEAD_BEEF, l2_opcode=0x03 only at G.
- Core 1 load miss, MISS_LAT=4, dmem_data=0x1234_5678 -> done=10 at G+6, rdata=0x1234_5678, l2_rd_en high G..G+5.
- Core 0 flush, addr 0x0000_2008, wdata 0xCAFE_0001 -> l2_flush=1 only at G, l2_bus_tag=0x000020, l2_bus_data=0xCAFE_0001, done=01 at G+1.
- req=2'b11 held for four transactions, all hits -> grant order 0,1,0,1; with L2_ARB_FIXED_PRIO_EN -> 0,0,0,0.
- Core 0 drops req during MISS -> transaction still completes with done=01.
- Reset asserted during MISS -> next cycle all outputs 0; no done; pointer = core 0.

Source files
------------

// File: rtl/l2_shared_arbiter_if.sv
// ============================================================================
// Module      : l2_shared_arbiter_if
// Description : Core request and L2 command/bus signals for the shared L2 arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface l2_shared_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  req_flush;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        l2_rd_en;
  logic        l2_flush;
  logic [6:0]  l2_opcode;
  logic [31:0] l2_bus_address;
  logic [31:0] l2_bus_data;
  logic [23:0] l2_bus_tag;
  logic [1:0]  l2_cache_hit;
  logic [31:0] l2_data;
  logic [31:0] dmem_data;

  // Requesters and the L2/data-memory environment.
  modport master (
    output req, req_flush, req_addr, req_wdata, l2_cache_hit, l2_data, dmem_data,
    input  gnt, done, rdata, l2_rd_en, l2_flush, l2_opcode,
           l2_bus_address, l2_bus_data, l2_bus_tag
  );

  // The arbiter/sequencer.
  modport slave (
    input  req, req_flush, req_addr, req_wdata, l2_cache_hit, l2_data, dmem_data,
    output gnt, done, rdata, l2_rd_en, l2_flush, l2_opcode,
           l2_bus_address, l2_bus_data, l2_bus_tag
  );
endinterface

`default_nettype wire

// File: rtl/l2_shared_arbiter.sv
// ============================================================================
// Module      : l2_shared_arbiter
// Description : Two-core arbiter and hit/miss/flush sequencer for the shared L2.
//               Define L2_ARB_FIXED_PRIO_EN for fixed core-0 priority.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module l2_shared_arbiter #(
  parameter int unsigned MISS_LAT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  l2_shared_arbiter_if.slave   bus
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [3:0] MISS_INIT = 4'(MISS_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    MISS  = 3'd2,
    FILL  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  miss_cnt;
  logic        win;
  logic        op_flush;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [31:0] rdata_q;
  logic        rd_en_q;
  logic        flush_q;
  logic [6:0]  opcode_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [23:0] tag_q;

  logic        pick;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_flush;

`ifdef L2_ARB_FIXED_PRIO_EN
  assign pick = ~bus.req[0];
`else
  logic ptr;

  // Both requesting: pointer core wins; otherwise the sole requester.
  assign pick = (&bus.req) ? ptr : bus.req[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (state == RESP) begin
      ptr <= ~win;
    end
  end
`endif

  assign sel_addr  = pick ? bus.req_addr[63:32]  : bus.req_addr[31:0];
  assign sel_wdata = pick ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
  assign sel_flush = bus.req_flush[pick];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      miss_cnt <= 4'd0;
      win      <= 1'b0;
      op_flush <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rdata_q  <= 32'd0;
      rd_en_q  <= 1'b0;
      flush_q  <= 1'b0;
      opcode_q <= 7'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      tag_q    <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            win      <= pick;
            op_flush <= sel_flush;
            addr_q   <= sel_addr;
            tag_q    <= sel_addr[31:8];
            data_q   <= sel_flush ? sel_wdata : 32'd0;
            gnt_q    <= {pick, ~pick};
            flush_q  <= sel_flush;
            rd_en_q  <= ~sel_flush;
            opcode_q <= sel_flush ? 7'd0 : OPC_LOAD;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          gnt_q <= 2'b00;
          if (op_flush) begin
            flush_q <= 1'b0;
            done_q  <= {win, ~win};
            state   <= RESP;
          end else if (bus.l2_cache_hit == 2'b10) begin
            rdata_q  <= bus.l2_data;
            rd_en_q  <= 1'b0;
            opcode_q <= 7'd0;
            done_q   <= {win, ~win};
            state    <= RESP;
          end else begin
            // Anything other than a clean hit is treated as a miss.
            miss_cnt <= MISS_INIT;
            state    <= MISS;
          end
        end
        MISS: begin
          if (miss_cnt == 4'd0) begin
            state <= FILL;
          end else begin
            miss_cnt <= miss_cnt - 4'd1;
          end
        end
        FILL: begin
          rdata_q  <= bus.dmem_data;
          rd_en_q  <= 1'b0;
          opcode_q <= 7'd0;
          done_q   <= {win, ~win};
          state    <= RESP;
        end
        RESP: begin
          done_q <= 2'b00;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.done           = done_q;
  assign bus.rdata          = rdata_q;
  assign bus.l2_rd_en       = rd_en_q;
  assign bus.l2_flush       = flush_q;
  assign bus.l2_opcode      = opcode_q;
  assign bus.l2_bus_address = addr_q;
  assign bus.l2_bus_data    = data_q;
  assign bus.l2_bus_tag     = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_l2_shared_arbiter.sv
// ============================================================================
// Module      : tb_l2_shared_arbiter
// Description : Directed plus randomized bench for l2_shared_arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_l2_shared_arbiter;
  localparam int MISS_LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l2_shared_arbiter_if bus();

  l2_shared_arbiter #(.MISS_LAT(MISS_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: each grant opens a transaction whose outputs
  // are a function of its cycle offset from the grant cycle.
  int          cyc = 0;
  bit          m_valid = 0;
  bit          m_active = 0;
  int          m_g = 0;
  int          m_end = -1;
  bit          m_win = 0;
  bit          m_flush = 0;
  bit          m_ptr = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  task automatic compare_cycle();
    logic [1:0] eg, ed;
    logic       erd, efl;
    logic [6:0] eop;
    bit         bus_chk;
    int         k;
    eg = 2'b00; ed = 2'b00; erd = 1'b0; efl = 1'b0; eop = 7'd0; bus_chk = 0;
    if (m_active) begin
      k = cyc - m_g;
      if (k == 0) begin
        eg = m_win ? 2'b10 : 2'b01;
        if (m_flush) efl = 1'b1;
        else begin erd = 1'b1; eop = 7'h03; end
        bus_chk = 1;
      end else if (cyc == m_end) begin
        ed = m_win ? 2'b10 : 2'b01;
      end else begin
        erd = 1'b1; eop = 7'h03; bus_chk = 1;
      end
    end
    check("gnt",       64'(bus.gnt),       64'(eg));
    check("done",      64'(bus.done),      64'(ed));
    check("l2_rd_en",  64'(bus.l2_rd_en),  64'(erd));
    check("l2_flush",  64'(bus.l2_flush),  64'(efl));
    check("l2_opcode", 64'(bus.l2_opcode), 64'(eop));
    check("rdata",     64'(bus.rdata),     64'(m_rdata));
    if (bus_chk) begin
      check("l2_bus_address", 64'(bus.l2_bus_address), 64'(m_addr));
      check("l2_bus_tag",     64'(bus.l2_bus_tag),     64'(m_addr[31:8]));
      check("l2_bus_data",    64'(bus.l2_bus_data),    64'(m_flush ? m_wdata : 32'd0));
    end
  endtask

  task automatic model_step();
    int k;
    if (reset) begin
      m_valid = 1; m_active = 0; m_ptr = 0; m_rdata = '0; m_end = -1;
    end else if (m_valid) begin
      if (m_active) begin
        k = cyc - m_g;
        if (k == 0) begin
          if (m_flush) m_end = m_g + 1;
          else if (bus.l2_cache_hit == 2'b10) begin
            m_end = m_g + 1;
            m_rdata = bus.l2_data;
          end else m_end = m_g + MISS_LAT + 2;
        end else if (!m_flush && m_end == m_g + MISS_LAT + 2 && k == MISS_LAT + 1) begin
          m_rdata = bus.dmem_data;
        end
        if (k > 0 && cyc == m_end) begin
          m_active = 0;
          m_ptr = !m_win;
        end
      end else if (bus.req != 2'b00) begin
`ifdef L2_ARB_FIXED_PRIO_EN
        m_win = (bus.req == 2'b11) ? 1'b0 : (bus.req == 2'b10);
`else
        m_win = (bus.req == 2'b11) ? m_ptr : (bus.req == 2'b10);
`endif
        m_flush = bus.req_flush[m_win];
        m_addr  = m_win ? bus.req_addr[63:32]  : bus.req_addr[31:0];
        m_wdata = m_win ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
        m_g = cyc + 1;
        m_end = -1;
        m_active = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    cyc++;
    if (m_valid) compare_cycle();
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input bit fl, input logic [31:0] a, input logic [31:0] d);
    bus.req[n] = 1'b1;
    bus.req_flush[n] = fl;
    bus.req_addr[32*n +: 32] = a;
    bus.req_wdata[32*n +: 32] = d;
  endtask

  task automatic wait_gnt(input string name);
    for (int i = 0; i < 30; i++) begin
      if (bus.gnt != 2'b00) break;
      tick();
    end
    check(name, 64'(bus.gnt != 2'b00), 64'd1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 30; i++) begin
      if (bus.done != 2'b00) break;
      tick();
    end
    check(name, 64'(bus.done != 2'b00), 64'd1);
  endtask

  logic [3:0] order;
  logic [3:0] exp_order;

  initial begin
    bus.req = '0; bus.req_flush = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.l2_cache_hit = '0; bus.l2_data = '0; bus.dmem_data = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_gnt",   64'(bus.gnt),       64'd0);
    check("rst_done",  64'(bus.done),      64'd0);
    check("rst_rdata", 64'(bus.rdata),     64'd0);
    check("rst_rd_en", 64'(bus.l2_rd_en),  64'd0);
    check("rst_op",    64'(bus.l2_opcode), 64'd0);

    // Core 0 load hit
    set_req(0, 1'b0, 32'h0000_1004, 32'd0);
    bus.l2_cache_hit = 2'b10; bus.l2_data = 32'hDEAD_BEEF;
    tick();
    check("s1_gnt_G",    64'(bus.gnt),            64'h1);
    check("s1_opcode_G", 64'(bus.l2_opcode),      64'h03);
    check("s1_addr_G",   64'(bus.l2_bus_address), 64'h1004);
    tick();
    check("s1_done",     64'(bus.done),           64'h1);
    check("s1_rdata",    64'(bus.rdata),          64'hDEAD_BEEF);
    check("s1_opcode",   64'(bus.l2_opcode),      64'h0);
    bus.req = 2'b00;
    tick();

    // Core 1 load miss
    set_req(1, 1'b0, 32'h0000_3000, 32'd0);
    bus.l2_cache_hit = 2'b01; bus.dmem_data = 32'h1234_5678;
    tick();
    check("s2_gnt_G",  64'(bus.gnt),      64'h2);
    check("s2_rd_en_G", 64'(bus.l2_rd_en), 64'h1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("s2_rd_en_miss", 64'(bus.l2_rd_en), 64'h1);
      check("s2_no_done",    64'(bus.done),     64'h0);
    end
    tick();
    check("s2_done",  64'(bus.done),     64'h2);
    check("s2_rdata", 64'(bus.rdata),    64'h1234_5678);
    check("s2_rd_en", 64'(bus.l2_rd_en), 64'h0);
    bus.req = 2'b00;
    tick();

    // Core 0 flush
    set_req(0, 1'b1, 32'h0000_2008, 32'hCAFE_0001);
    tick();
    check("s3_gnt_G",   64'(bus.gnt),         64'h1);
    check("s3_flush_G", 64'(bus.l2_flush),    64'h1);
    check("s3_tag",     64'(bus.l2_bus_tag),  64'h000020);
    check("s3_data",    64'(bus.l2_bus_data), 64'hCAFE_0001);
    check("s3_rd_en_G", 64'(bus.l2_rd_en),    64'h0);
    tick();
    check("s3_done",    64'(bus.done),        64'h1);
    check("s3_flush",   64'(bus.l2_flush),    64'h0);
    bus.req = 2'b00;
    tick();

    // Both cores request continuously, all hits
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, 32'h0000_0100, 32'd0);
    set_req(1, 1'b0, 32'h0000_0200, 32'd0);
    bus.l2_cache_hit = 2'b10; bus.l2_data = 32'h0BAD_F00D;
    order = '0;
    for (int t = 0; t < 4; t++) begin
      wait_gnt("s4_gnt_timeout");
      order[t] = bus.gnt[1];
      tick();
    end
`ifdef L2_ARB_FIXED_PRIO_EN
    exp_order = 4'b0000;
`else
    exp_order = 4'b1010;
`endif
    check("s4_order", 64'(order), 64'(exp_order));
    bus.req = 2'b00;
    repeat (3) tick();

    // Core 0 drops req during the miss wait
    set_req(0, 1'b0, 32'h0000_4000, 32'd0);
    bus.l2_cache_hit = 2'b01; bus.dmem_data = 32'hA5A5_0F0F;
    tick();
    check("s5_gnt_G", 64'(bus.gnt), 64'h1);
    tick();
    tick();
    bus.req[0] = 1'b0;
    wait_done("s5_done_timeout");
    check("s5_done",  64'(bus.done),  64'h1);
    check("s5_rdata", 64'(bus.rdata), 64'hA5A5_0F0F);
    tick();

    // Reset during a core 1 miss
    set_req(1, 1'b0, 32'h0000_5000, 32'd0);
    bus.l2_cache_hit = 2'b01;
    tick();
    check("s6_gnt_G", 64'(bus.gnt), 64'h2);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s6_gnt",   64'(bus.gnt),            64'h0);
    check("s6_done",  64'(bus.done),           64'h0);
    check("s6_rdata", 64'(bus.rdata),          64'h0);
    check("s6_rd_en", 64'(bus.l2_rd_en),       64'h0);
    check("s6_op",    64'(bus.l2_opcode),      64'h0);
    check("s6_addr",  64'(bus.l2_bus_address), 64'h0);
    check("s6_tag",   64'(bus.l2_bus_tag),     64'h0);
    set_req(0, 1'b0, 32'h0000_6000, 32'd0);
    bus.l2_cache_hit = 2'b10;
    tick();
    check("s6_ptr_reset_gnt", 64'(bus.gnt), 64'h1);
    bus.req = 2'b00;
    repeat (4) tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
      for (int n = 0; n < 2; n++) begin
        if (bus.req[n] && bus.done[n]) bus.req[n] = 1'b0;
        else if (!bus.req[n] && $urandom_range(0, 2) == 0)
          set_req(n, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      bus.l2_cache_hit = 2'($urandom_range(0, 3));
      bus.l2_data = $urandom;
      bus.dmem_data = $urandom;
    end
    reset = 1'b0;
    bus.req = 2'b00;
    repeat (12) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
